// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI chip-select controller and its TX FIFO.
package spi_pkg;

  localparam int TX_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CS_SETUP  = 3'd1,
    ST_XFER      = 3'd2,
    ST_WAIT_LAST = 3'd3,
    ST_CS_HOLD   = 3'd4,
    ST_CS_GAP    = 3'd5
  } state_t;

  // Chip select is low from setup through hold; high in idle and the gap.
  function automatic logic cs_active(input state_t s);
    return (s == ST_CS_SETUP) || (s == ST_XFER) ||
           (s == ST_WAIT_LAST) || (s == ST_CS_HOLD);
  endfunction

endpackage

// File: rtl/spi_cs_ctrl_if.sv
// Host and byte-engine signal bundle for spi_cs_ctrl, plus the FSM debug view.
interface spi_cs_ctrl_if #(parameter int CNT_W = 8);

  // Handshakes: host byte moves when i_TX_DV=1 and o_TX_Ready=1 in the same
  // cycle; the engine takes a byte on the single-cycle o_M_DV pulse, which is
  // only raised while i_M_Ready=1; i_M_RX_DV/o_RX_DV are unacknowledged pulses.
  logic [CNT_W-1:0] i_TX_Count;
  logic [7:0]       i_TX_Byte;
  logic             i_TX_DV;
  logic             o_TX_Ready;
  logic [7:0]       o_M_Byte;
  logic             o_M_DV;
  logic             i_M_Ready;
  logic             i_M_RX_DV;
  logic [7:0]       i_M_RX_Byte;
  logic             o_RX_DV;
  logic [7:0]       o_RX_Byte;
  logic [CNT_W-1:0] o_RX_Index;
  logic             o_SPI_CS_n;
  logic             o_Busy;
  spi_pkg::state_t  dbg_state;

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_Ready, i_M_RX_DV, i_M_RX_Byte,
    output o_TX_Ready, o_M_Byte, o_M_DV, o_RX_DV, o_RX_Byte, o_RX_Index,
           o_SPI_CS_n, o_Busy, dbg_state
  );

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_Ready, i_M_RX_DV, i_M_RX_Byte,
    input  o_TX_Ready, o_M_Byte, o_M_DV, o_RX_DV, o_RX_Byte, o_RX_Index,
           o_SPI_CS_n, o_Busy, dbg_state
  );

endinterface

// File: rtl/spi_cs_ctrl_tx_fifo.sv
// 8-bit TX FIFO with full/empty flags; only compiled when SPI_CS_CTRL_TXFIFO_EN
// is defined, since only that build of spi_cs_ctrl instantiates it.
`ifdef SPI_CS_CTRL_TXFIFO_EN
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   used;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (used == (PW+1)'(DEPTH));
  assign empty   = (used == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally, so DEPTH must be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

endmodule
`endif

// File: rtl/spi_cs_ctrl.sv
// SPI chip-select framing controller: buffers host bytes, paces them into a byte
// engine and frames the transaction with CS_n. SPI_CS_CTRL_TXFIFO_EN selects a
// 4-entry TX FIFO instead of the single holding register.
module spi_cs_ctrl
  import spi_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int CS_LEAD_CLKS = 2,
  parameter int CS_LAG_CLKS  = 2,
  parameter int CS_IDLE_CLKS = 4
) (
  input logic          i_Clk,
  input logic          i_Rst_n,
  spi_cs_ctrl_if.slave bus
);

  localparam logic [7:0] LEAD_M1 = 8'(CS_LEAD_CLKS - 1);
  localparam logic [7:0] LAG_M1  = 8'(CS_LAG_CLKS - 1);
  localparam logic [7:0] GAP_M1  = 8'(CS_IDLE_CLKS - 1);

  state_t           state;
  state_t           next_state;
  logic [7:0]       timer;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] rx_idx;
  logic             rst_done;
  logic             dv_d1;
  logic             dv_d2;
  logic             cs_on;
  logic             tx_ready;
  logic             accept;
  logic             issue;
  logic             last_issue;
  logic             rx_in;
  logic             buf_valid;
  logic             buf_full;
  logic [7:0]       buf_head;
  logic             rx_dv_q;
  logic [7:0]       rx_byte_q;
  logic [CNT_W-1:0] rx_index_q;

  assign cs_on    = cs_active(state);
  assign tx_ready = rst_done &&
                    ((state == ST_IDLE) ||
                     (((state == ST_CS_SETUP) || (state == ST_XFER)) &&
                      !buf_full && (acc_cnt < count)));
  // A zero-count request in idle is swallowed without starting a frame.
  assign accept     = bus.i_TX_DV && tx_ready &&
                      ((state != ST_IDLE) || (bus.i_TX_Count != '0));
  // Two-cycle spacing gives the engine time to drop i_M_Ready after a pulse.
  assign issue      = (state == ST_XFER) && buf_valid && bus.i_M_Ready &&
                      !dv_d1 && !dv_d2;
  assign last_issue = issue && (iss_cnt == count - CNT_W'(1));
  assign rx_in      = bus.i_M_RX_DV && cs_on;

`ifdef SPI_CS_CTRL_TXFIFO_EN
  logic fifo_empty;

  spi_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .push  (accept),
    .din   (bus.i_TX_Byte),
    .pop   (issue),
    .dout  (buf_head),
    .full  (buf_full),
    .empty (fifo_empty)
  );

  assign buf_valid = !fifo_empty;
`else
  logic       hold_valid;
  logic [7:0] hold_byte;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_valid <= 1'b0;
      hold_byte  <= '0;
    end else begin
      if (issue) hold_valid <= 1'b0;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_byte  <= bus.i_TX_Byte;
      end
    end
  end

  assign buf_valid = hold_valid;
  assign buf_full  = hold_valid;
  assign buf_head  = hold_byte;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (accept) next_state = ST_CS_SETUP;
      ST_CS_SETUP:  if (timer == '0) next_state = ST_XFER;
      ST_XFER:      if (last_issue) next_state = ST_WAIT_LAST;
      ST_WAIT_LAST: if (rx_in && (rx_idx == count - CNT_W'(1))) next_state = ST_CS_HOLD;
      ST_CS_HOLD:   if (timer == '0) next_state = ST_CS_GAP;
      ST_CS_GAP:    if (timer == '0) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_SPI_CS_n = !cs_on;
    bus.o_Busy     = (state != ST_IDLE);
    bus.o_TX_Ready = tx_ready;
    bus.o_M_DV     = issue;
    bus.o_M_Byte   = buf_head;
    bus.o_RX_DV    = rx_dv_q;
    bus.o_RX_Byte  = rx_byte_q;
    bus.o_RX_Index = rx_index_q;
    bus.dbg_state  = state;
  end

  // Phase timer is loaded with length-1 on entry to each timed state.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      timer <= '0;
    end else if (next_state != state) begin
      case (next_state)
        ST_CS_SETUP: timer <= LEAD_M1;
        ST_CS_HOLD:  timer <= LAG_M1;
        ST_CS_GAP:   timer <= GAP_M1;
        default:     timer <= '0;
      endcase
    end else if (timer != '0) begin
      timer <= timer - 8'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rst_done <= 1'b0;
      count    <= '0;
      acc_cnt  <= '0;
      iss_cnt  <= '0;
      rx_idx   <= '0;
      dv_d1    <= 1'b0;
      dv_d2    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      dv_d1    <= issue;
      dv_d2    <= dv_d1;
      if (state == ST_IDLE) begin
        acc_cnt <= accept ? CNT_W'(1) : '0;
        iss_cnt <= '0;
        rx_idx  <= '0;
        if (accept) count <= bus.i_TX_Count;
      end else begin
        if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
        if (issue)  iss_cnt <= iss_cnt + CNT_W'(1);
        if (rx_in && (rx_idx != '1)) rx_idx <= rx_idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
      rx_index_q <= '0;
    end else begin
      rx_dv_q <= rx_in;
      if (rx_in) begin
        rx_byte_q  <= bus.i_M_RX_Byte;
        rx_index_q <= rx_idx;
      end
    end
  end

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Directed bench for spi_cs_ctrl: host driver, echoing byte-engine model and a
// queue-based monitor that checks bytes, indices and CS framing.
module tb_spi_cs_ctrl;

  localparam int ENG_LAT = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic [7:0]  exp_m_q[$];
  logic [15:0] exp_rx_q[$];

  int   n_falls;
  int   fall_cyc;
  int   last_rx_cyc;
  int   last_mdv_cyc;
  int   last_acc_cyc;
  int   high_run;
  logic first_in_window;
  logic rx_seen;
  logic prev_cs;
  logic [7:0] eng_byte;

  spi_cs_ctrl_if #(.CNT_W(8)) bus ();

  spi_cs_ctrl #(
    .CNT_W(8), .CS_LEAD_CLKS(2), .CS_LAG_CLKS(2), .CS_IDLE_CLKS(4)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  // Clock, cycle counter and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Host driver: waits for o_TX_Ready, pulses i_TX_DV for one cycle.
  task automatic host_send(input logic [7:0] b, input logic [7:0] cnt, output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.o_TX_Ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check("host_ready_timeout", {31'd0, bus.o_TX_Ready}, 1);
    bus.i_TX_Byte  = b;
    bus.i_TX_Count = cnt;
    bus.i_TX_DV    = 1'b1;
    last_acc_cyc   = cyc;
    @(posedge clk);
    #1 bus.i_TX_DV = 1'b0;
`ifndef SPI_CS_CTRL_TXFIFO_EN
    if (cnt != 0) check("ready_drop_after_accept", {31'd0, bus.o_TX_Ready}, 0);
`endif
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_m_q.size() != 0 || exp_rx_q.size() != 0 || bus.o_Busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, {31'd0, (t < 400)}, 1);
  endtask

  // Byte-engine model: drops ready after a pulse, echoes byte ^ 0x99 later.
  initial begin
    bus.i_M_Ready   = 1'b1;
    bus.i_M_RX_DV   = 1'b0;
    bus.i_M_RX_Byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_M_DV) begin
        eng_byte = bus.o_M_Byte;
        @(posedge clk);
        #1 bus.i_M_Ready = 1'b0;
        repeat (ENG_LAT) @(posedge clk);
        #1;
        bus.i_M_RX_DV   = 1'b1;
        bus.i_M_RX_Byte = eng_byte ^ 8'h99;
        @(posedge clk);
        #1;
        bus.i_M_RX_DV = 1'b0;
        bus.i_M_Ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    n_falls = 0; fall_cyc = 0; last_rx_cyc = 0; last_mdv_cyc = 0;
    high_run = 0; first_in_window = 1'b0; rx_seen = 1'b0; prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_M_DV) begin
        if (exp_m_q.size() == 0) check("m_dv_unexpected", {24'd0, bus.o_M_Byte}, 32'hFFFF_FFFF);
        else check("m_byte", {24'd0, bus.o_M_Byte}, {24'd0, exp_m_q.pop_front()});
        check("m_dv_cs_low", {31'd0, bus.o_SPI_CS_n}, 0);
        last_mdv_cyc = cyc;
        if (first_in_window) begin
          check("cs_lead", cyc - fall_cyc, 2);
          first_in_window = 1'b0;
        end
      end
      if (rst_n && bus.o_RX_DV) begin
        if (exp_rx_q.size() == 0)
          check("rx_dv_unexpected", {16'd0, bus.o_RX_Index, bus.o_RX_Byte}, 32'hFFFF_FFFF);
        else
          check("rx_idx_byte", {16'd0, bus.o_RX_Index, bus.o_RX_Byte}, {16'd0, exp_rx_q.pop_front()});
        rx_seen     = 1'b1;
        last_rx_cyc = cyc;
      end
      if (prev_cs && !bus.o_SPI_CS_n) begin
        n_falls++;
        fall_cyc        = cyc;
        first_in_window = 1'b1;
        check("cs_high_gap", {31'd0, (high_run >= 4)}, 1);
        high_run = 0;
      end
      if (!prev_cs && bus.o_SPI_CS_n) begin
        if (rx_seen && rst_n) check("cs_lag", cyc - last_rx_cyc, 2);
        rx_seen = 1'b0;
      end
      if (bus.o_SPI_CS_n) high_run++;
      prev_cs = bus.o_SPI_CS_n;
    end
  end

  // Directed tests
  initial begin
    int   w;
    int   f0;
    int   t;
    logic any_low;
    logic any_busy;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.i_TX_DV = 1'b0; bus.i_TX_Byte = 8'h00; bus.i_TX_Count = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n",     {31'd0, bus.o_SPI_CS_n}, 1);
    check("rst_m_dv",     {31'd0, bus.o_M_DV}, 0);
    check("rst_m_byte",   {24'd0, bus.o_M_Byte}, 0);
    check("rst_rx_dv",    {31'd0, bus.o_RX_DV}, 0);
    check("rst_rx_byte",  {24'd0, bus.o_RX_Byte}, 0);
    check("rst_rx_index", {24'd0, bus.o_RX_Index}, 0);
    check("rst_tx_ready", {31'd0, bus.o_TX_Ready}, 0);
    check("rst_busy",     {31'd0, bus.o_Busy}, 0);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", {31'd0, bus.o_TX_Ready}, 0);
    @(posedge clk);
    #1 check("ready_after_first_edge", {31'd0, bus.o_TX_Ready}, 1);

    // Single byte 0xA5 echoed as 0x3C, then a 3-byte frame right behind it
    f0 = n_falls;
    exp_m_q.push_back(8'hA5); exp_rx_q.push_back({8'd0, 8'h3C});
    host_send(8'hA5, 8'd1, w);
    exp_m_q.push_back(8'h01); exp_rx_q.push_back({8'd0, 8'h98});
    exp_m_q.push_back(8'h02); exp_rx_q.push_back({8'd1, 8'h9B});
    exp_m_q.push_back(8'h03); exp_rx_q.push_back({8'd2, 8'h9A});
    host_send(8'h01, 8'd3, w);
    host_send(8'h02, 8'd3, w);
    host_send(8'h03, 8'd3, w);
    wait_done("count3_done");
    check("two_frames_two_windows", n_falls - f0, 2);

    // Zero count: no chip-select activity at all
    f0 = n_falls; any_low = 1'b0; any_busy = 1'b0;
    host_send(8'hEE, 8'd0, w);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      any_low  = any_low | !bus.o_SPI_CS_n;
      any_busy = any_busy | bus.o_Busy;
    end
    check("count0_cs_stays_high", {31'd0, any_low}, 0);
    check("count0_busy_stays_low", {31'd0, any_busy}, 0);
    check("count0_no_window", n_falls - f0, 0);

    // Underrun: second byte 20 cycles late, CS must stay low
    f0 = n_falls;
    exp_m_q.push_back(8'h5A); exp_rx_q.push_back({8'd0, 8'hC3});
    exp_m_q.push_back(8'hC3); exp_rx_q.push_back({8'd1, 8'h5A});
    host_send(8'h5A, 8'd2, w);
    repeat (20) @(posedge clk);
    check("underrun_cs_low", {31'd0, bus.o_SPI_CS_n}, 0);
    check("underrun_no_m_dv_pending", exp_m_q.size(), 1);
    host_send(8'hC3, 8'd2, w);
    wait_done("underrun_done");
    check("underrun_single_window", n_falls - f0, 1);
    check("late_byte_dv_delay", last_mdv_cyc - last_acc_cyc, 1);

    // Four bytes; the FIFO build takes them without stalling
    exp_m_q.push_back(8'h11); exp_rx_q.push_back({8'd0, 8'h88});
    exp_m_q.push_back(8'h22); exp_rx_q.push_back({8'd1, 8'hBB});
    exp_m_q.push_back(8'h33); exp_rx_q.push_back({8'd2, 8'hAA});
    exp_m_q.push_back(8'h44); exp_rx_q.push_back({8'd3, 8'hDD});
    host_send(8'h11, 8'd4, w);
    host_send(8'h22, 8'd4, w);
`ifdef SPI_CS_CTRL_TXFIFO_EN
    check("fifo_no_stall_b2", w, 0);
`endif
    host_send(8'h33, 8'd4, w);
`ifdef SPI_CS_CTRL_TXFIFO_EN
    check("fifo_no_stall_b3", w, 0);
`endif
    host_send(8'h44, 8'd4, w);
`ifdef SPI_CS_CTRL_TXFIFO_EN
    check("fifo_no_stall_b4", w, 0);
`endif
    wait_done("count4_done");

    // Reset after the first byte of a 4-byte frame, then a fresh transfer
    exp_m_q.push_back(8'h77);
    host_send(8'h77, 8'd4, w);
    t = 0;
    while (exp_m_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("abort_first_dv_seen", {31'd0, (t < 100)}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_cs_high_now", {31'd0, bus.o_SPI_CS_n}, 1);
    check("abort_busy_low", {31'd0, bus.o_Busy}, 0);
    check("abort_tx_ready_low", {31'd0, bus.o_TX_Ready}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_idle_after", {31'd0, bus.o_Busy}, 0);
    exp_m_q.push_back(8'hA5); exp_rx_q.push_back({8'd0, 8'h3C});
    host_send(8'hA5, 8'd1, w);
    wait_done("post_reset_done");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_cs_ctrl.md
SPI_CS_CTRL -- requirements
Module: spi_cs_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the byte-count and byte-index fields; at most 2^CNT_W-1 bytes per transaction.
REQ-002 SHALL have parameter CS_LEAD_CLKS, default 2: i_Clk cycles from CS_n falling to the first byte issued.
REQ-003 SHALL have parameter CS_LAG_CLKS, default 2: i_Clk cycles from the last RX byte to CS_n rising.
REQ-004 SHALL have parameter CS_IDLE_CLKS, default 4: minimum i_Clk cycles CS_n stays high between transactions.
REQ-005 SHALL have port i_Clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_TX_Count, input, CNT_W bits: transaction byte count; sampled only with the first i_TX_DV in IDLE.
REQ-008 SHALL have port i_TX_Byte, input, 8 bits: host byte to send.
REQ-009 SHALL have port i_TX_DV, input, 1 bit: host byte-valid pulse; honoured only while o_TX_Ready=1.
REQ-010 SHALL have port o_TX_Ready, output, 1 bit: controller can accept a host byte this cycle.
REQ-011 SHALL have port o_M_Byte, output, 8 bits: byte presented to the downstream SPI byte engine.
REQ-012 SHALL have port o_M_DV, output, 1 bit: single-cycle pulse to the engine carrying o_M_Byte.
REQ-013 SHALL have port i_M_Ready, input, 1 bit: engine idle and ready; the engine drops it the cycle after o_M_DV.
REQ-014 SHALL have port i_M_RX_DV, input, 1 bit: engine received-byte pulse.
REQ-015 SHALL have port i_M_RX_Byte, input, 8 bits: engine received byte.
REQ-016 SHALL have port o_RX_DV, output, 1 bit: registered copy of i_M_RX_DV, passed to the host.
REQ-017 SHALL have port o_RX_Byte, output, 8 bits: registered copy of i_M_RX_Byte.
REQ-018 SHALL have port o_RX_Index, output, CNT_W bits: 0-based position of o_RX_Byte within the transaction.
REQ-019 SHALL have port o_SPI_CS_n, output, 1 bit: chip select, active-low.
REQ-020 SHALL have port o_Busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-021 SHALL implement FSM IDLE->CS_SETUP->XFER->WAIT_LAST->CS_HOLD->CS_GAP->IDLE.
REQ-022 IDLE: on i_TX_DV with i_TX_Count!=0, SHALL latch the count and buffer the byte, drive CS_n low the next cycle, and enter CS_SETUP.
REQ-022a IDLE: i_TX_DV with count 0 SHALL be dropped with no CS activity.
REQ-023 CS_SETUP SHALL last exactly CS_LEAD_CLKS cycles, then enter XFER.
REQ-024 XFER SHALL pulse o_M_DV for one cycle only when all three hold: a byte is buffered, i_M_Ready=1, and o_M_DV was 0 in the previous two cycles.
REQ-025 After issuing the byte numbered i_TX_Count, SHALL enter WAIT_LAST.
REQ-025a o_TX_Ready SHALL be 0 once i_TX_Count bytes have been accepted.
REQ-026 o_TX_Ready SHALL be 1 in IDLE and, during CS_SETUP/XFER, while buffer space exists and accepted bytes < count.
REQ-027 WAIT_LAST SHALL advance to CS_HOLD on the i_M_RX_DV whose index equals count-1.
REQ-028 CS_HOLD SHALL keep CS_n low for CS_LAG_CLKS cycles; CS_GAP SHALL hold CS_n high for CS_IDLE_CLKS cycles, then return to IDLE.
REQ-029 Every i_M_RX_DV while CS_n is low SHALL produce o_RX_DV one cycle later with the matching byte and an o_RX_Index incrementing from 0.
REQ-029a i_M_RX_DV while CS_n is high SHALL be ignored.
REQ-030 Index and count counters SHALL be CNT_W bits, cleared on IDLE entry, and SHALL NOT wrap within a transaction.
REQ-031 A host underrun SHALL leave CS_n asserted and the FSM waiting in XFER with no o_M_DV.
REQ-032 Simultaneous host accept and engine issue in one cycle SHALL both take effect with no byte lost or duplicated.

Reset
REQ-033 On i_Rst_n low, at any time including mid-transaction, SHALL force IDLE and clear the buffer.
REQ-033a Output reset values SHALL be: o_SPI_CS_n=1, o_M_DV=0, o_M_Byte=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Index=0, o_TX_Ready=0, o_Busy=0.
REQ-033b o_TX_Ready SHALL rise on the first clock after reset release.

Configuration
REQ-034 With SPI_CS_CTRL_TXFIFO_EN defined, the TX buffer SHALL be a 4-entry FIFO, so the host may preload up to 4 bytes during CS_SETUP.
REQ-035 Without SPI_CS_CTRL_TXFIFO_EN, the TX buffer SHALL be a single holding register; o_TX_Ready SHALL be 0 while it is full.

Structure
REQ-036 A shared package spi_pkg SHALL hold the FSM state encoding and the FIFO depth constant (4).
REQ-037 The FIFO SHALL be a sub-module spi_tx_fifo, 8-bit wide with full/empty flags, instantiated only under SPI_CS_CTRL_TXFIFO_EN.

Verification
REQ-038 Count=1, byte 0xA5, engine model echoing 0x3C -> CS_n low 2 cycles before o_M_DV; o_RX_Byte=0x3C with index 0; CS_n high 2 cycles after o_RX_DV.
REQ-039 Count=3, bytes 0x01/0x02/0x03 back-to-back -> three o_M_DV pulses in order, indices 0,1,2, a single CS_n low window, then CS_n high >=4 cycles.
REQ-040 Count=0 with i_TX_DV -> CS_n stays 1, o_Busy stays 0, no o_M_DV.
REQ-041 Count=2, second byte delayed 20 cycles -> CS_n held low throughout; second o_M_DV follows the late byte.
REQ-042 Reset asserted after the first o_M_DV of a count=4 transfer -> CS_n=1 immediately; a fresh count=1 transfer completes normally.
REQ-043 FIFO build: 4 bytes preloaded during CS_SETUP -> 4 o_M_DV pulses with no o_TX_Ready stall; register build: o_TX_Ready drops after each accept.
